// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared widths, halt opcode and fetch state encoding
package instruction_fetch_pkg;

    localparam int IF_INSTRUCTION_WIDTH = 64;
    localparam int IF_ROM_ADDRESS_WIDTH = 16;
    localparam int IF_OPCODE_WIDTH      = 16;
    localparam logic [IF_OPCODE_WIDTH-1:0] IF_HALT_OPCODE = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_EXE = 3'd4,
        S_HALTED   = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch unit control, ROM and execution-side signal bundle
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = IF_INSTRUCTION_WIDTH,
    parameter int ROM_ADDRESS_WIDTH = IF_ROM_ADDRESS_WIDTH
);
    logic                         iStart;
    logic [ROM_ADDRESS_WIDTH-1:0] iInitialIP;
    logic [ROM_ADDRESS_WIDTH-1:0] oRomAddress;
    logic [INSTRUCTION_WIDTH-1:0] iRomData;
    logic [INSTRUCTION_WIDTH-1:0] oEncodedInstruction;
    logic                         oInstructionAvailable;
    logic [ROM_ADDRESS_WIDTH-1:0] oCurrentIP;
    logic                         iExeDone;
    logic                         iBranchTaken;
    logic [ROM_ADDRESS_WIDTH-1:0] iBranchAddress;
    logic                         oBusy;
    logic                         oHalted;

    modport master (
        input  iStart, iInitialIP, iRomData, iExeDone, iBranchTaken, iBranchAddress,
        output oRomAddress, oEncodedInstruction, oInstructionAvailable, oCurrentIP,
               oBusy, oHalted
    );

    modport slave (
        output iStart, iInitialIP, iRomData, iExeDone, iBranchTaken, iBranchAddress,
        input  oRomAddress, oEncodedInstruction, oInstructionAvailable, oCurrentIP,
               oBusy, oHalted
    );
endinterface

// File: rtl/fetch_ip_register.sv
// rtl/fetch_ip_register.sv - instruction pointer register with load and wrapping increment
module fetch_ip_register
    import instruction_fetch_pkg::*;
#(
    parameter int ROM_ADDRESS_WIDTH = IF_ROM_ADDRESS_WIDTH
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iLoad,
    input  logic [ROM_ADDRESS_WIDTH-1:0] iLoadValue,
    input  logic                         iIncrement,
    output logic [ROM_ADDRESS_WIDTH-1:0] oIP
);
    logic [ROM_ADDRESS_WIDTH-1:0] ip_q;
    logic [ROM_ADDRESS_WIDTH-1:0] ip_d;

    // Load wins over increment; the add truncates so the top address wraps to zero.
    always_comb begin
        ip_d = ip_q;
        if (iLoad) begin
            ip_d = iLoadValue;
        end else if (iIncrement) begin
            ip_d = ip_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ip_q <= '0;
        end else begin
            ip_q <= ip_d;
        end
    end

    assign oIP = ip_q;
endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-issue instruction fetch sequencer over a 1-cycle-latency ROM
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = IF_INSTRUCTION_WIDTH,
    parameter int ROM_ADDRESS_WIDTH = IF_ROM_ADDRESS_WIDTH,
    parameter logic [IF_OPCODE_WIDTH-1:0] HALT_OPCODE = IF_HALT_OPCODE
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iStart,
    input  logic [ROM_ADDRESS_WIDTH-1:0] iInitialIP,
    output logic [ROM_ADDRESS_WIDTH-1:0] oRomAddress,
    input  logic [INSTRUCTION_WIDTH-1:0] iRomData,
    output logic [INSTRUCTION_WIDTH-1:0] oEncodedInstruction,
    output logic                         oInstructionAvailable,
    output logic [ROM_ADDRESS_WIDTH-1:0] oCurrentIP,
    input  logic                         iExeDone,
    input  logic                         iBranchTaken,
    input  logic [ROM_ADDRESS_WIDTH-1:0] iBranchAddress,
    output logic                         oBusy,
    output logic                         oHalted
);
    fetch_state_e                 state_q, state_d;
    logic [ROM_ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic [ROM_ADDRESS_WIDTH-1:0] cur_ip_q, cur_ip_d;
    logic                         avail_q, avail_d;
    logic                         busy_q, busy_d;
    logic                         halted_q, halted_d;

    logic                         ip_load;
    logic                         ip_inc;
    logic [ROM_ADDRESS_WIDTH-1:0] ip_load_value;
    logic [ROM_ADDRESS_WIDTH-1:0] ip;

    fetch_ip_register #(
        .ROM_ADDRESS_WIDTH(ROM_ADDRESS_WIDTH)
    ) u_ip (
        .Clock      (Clock),
        .Reset      (Reset),
        .iLoad      (ip_load),
        .iLoadValue (ip_load_value),
        .iIncrement (ip_inc),
        .oIP        (ip)
    );

    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        instr_d       = instr_q;
        cur_ip_d      = cur_ip_q;
        ip_load       = 1'b0;
        ip_inc        = 1'b0;
        ip_load_value = iInitialIP;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (iStart) begin
                    ip_load    = 1'b1;
                    rom_addr_d = iInitialIP;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                instr_d  = iRomData;
                cur_ip_d = ip;
                if (iRomData[INSTRUCTION_WIDTH-1 -: IF_OPCODE_WIDTH] == HALT_OPCODE) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT_EXE;
            S_WAIT_EXE: begin
                // ROM address is steered to the same value the IP register takes.
                if (iExeDone) begin
                    state_d = S_FETCH;
                    if (iBranchTaken) begin
                        ip_load       = 1'b1;
                        ip_load_value = iBranchAddress;
                        rom_addr_d    = iBranchAddress;
                    end else begin
                        ip_inc     = 1'b1;
                        rom_addr_d = ip + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        avail_d  = (state_d == S_ISSUE);
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALTED);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            instr_q    <= '0;
            cur_ip_q   <= '0;
            avail_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            instr_q    <= instr_d;
            cur_ip_q   <= cur_ip_d;
            avail_q    <= avail_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    assign oRomAddress           = rom_addr_q;
    assign oEncodedInstruction   = instr_q;
    assign oCurrentIP            = cur_ip_q;
    assign oInstructionAvailable = avail_q;
    assign oBusy                 = busy_q;
    assign oHalted               = halted_q;
endmodule
